dbus_mmio_responder: RTL and testbench
======================================

Name: dbus_mmio_responder

Overview:
- Memory-mapped I/O responder on the single-cycle core's data bus: the target end of the core's MemWrite/DataAdr/WriteData/ReadData accesses.
- Decodes a 256-byte window and provides four word registers:
  - a TX data port that pushes words into a FIFO drained over a valid/ready output stream;
  - status, cycle-counter and control registers.
- Sits beside dmem in top; the top mux selects ReadData from this block when hit=1.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, window base; only bits [31:8] are compared.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- mem_write  input  1  core MemWrite
- addr  input  32  core DataAdr
- wdata  input  32  core WriteData
- rdata  output  32  read data, combinational from addr
- hit  output  1  combinational; 1 when addr[31:8]==BASE_ADDR[31:8]
- out_valid  output  1  TX stream word available
- out_data  output  32  TX stream word (FIFO head)
- out_ready  input  1  sink accepts the word

Behaviour:
- Address map: offset = addr[7:2]; addr[1:0] are ignored.
  - 0x00 TXDATA: write pushes wdata; reads return 0.
  - 0x04 STATUS (read):
    - [7:0] count, zero-extended
    - [8] empty
    - [9] full
    - [23:16] ovf_cnt
    - other bits 0
  - 0x04 STATUS (write, any data): clears ovf_cnt.
  - 0x08 CYCLE: read returns cyc; write (any data) clears cyc.
  - 0x0C CTRL (read): {30'b0, 1'b0, en}.
  - 0x0C CTRL (write): en<=wdata[0]; if wdata[1]=1, flush (write-only, self-clearing).
  - Other offsets in the window: read 0, writes ignored.
- Reads are purely combinational, so they complete in the same cycle, as the single-cycle core requires.
- rdata=0 when hit=0.
- Writes take effect at the posedge where mem_write & hit are both 1.
- Reset values:
  - count 0, rd/wr pointers 0
  - ovf_cnt 0, cyc 0, en 1
  - out_valid 0
  - out_data is don't-care while out_valid=0
- Reset is asynchronous: out_valid drops immediately, and any in-flight stream word is discarded.
- FIFO:
  - out_valid = en & (count!=0).
  - out_data = entry at rd_ptr (combinational, no output register).
  - pop at posedge when out_valid & out_ready.
  - A word pushed at edge N is first visible on out_valid in cycle N+1; there is no empty bypass.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Push and pop in the same cycle:
  - count unchanged, both pointers advance;
  - this is legal even when full.
- Push when full and no pop that cycle:
  - the word is dropped;
  - ovf_cnt increments, saturating at 255;
  - FIFO contents are unchanged.
- Flush:
  - count<=0 and rd_ptr<=wr_ptr;
  - flush wins over a same-cycle pop.
  - A push cannot coincide with a flush (one bus write per cycle).
- en=0:
  - out_valid is forced 0; the FIFO holds its contents;
  - pushes continue, with overflow rules unchanged.
- Writing STATUS while an overflow occurs in the same cycle is not possible (single write port). Clearing ovf_cnt takes effect at the write edge.
- cyc:
  - 32-bit, increments every cycle, wraps 0xFFFF_FFFF -> 0;
  - a CYCLE write loads 0 at that edge, overriding the increment.
- Stream handshake rules:
  - out_data must stay stable while out_valid=1 and out_ready=0;
  - out_valid must not be withdrawn, except by reset, flush or en cleared via CTRL.

Decomposition:
- Package dbus_mmio_pkg holds:
  - offset constants OFF_TXDATA=6'h00, OFF_STATUS=6'h01, OFF_CYCLE=6'h02, OFF_CTRL=6'h03 (word indices);
  - STATUS bit positions;
  - CTRL bit positions EN_BIT=0, FLUSH_BIT=1.
- One sub-module, mmio_tx_fifo:
  - parameterised synchronous FIFO with push/pop/flush inputs;
  - count/full/empty/head outputs;
  - asynchronous reset.
- The address decode, registers and overflow counter stay in the top module.

Test Plan:
- Reset:
  - Stimulus: reset high mid-stream with count=3.
  - Required: out_valid=0 immediately; after release, STATUS read = 32'h0000_0100 (empty), CTRL = 1, CYCLE starts from 0.
- Push/drain order:
  - Stimulus: write 0x11,0x22,0x33 to BASE+0x00 on consecutive cycles, out_ready=1.
  - Required: out_data 0x11,0x22,0x33 in order, first valid one cycle after the first write; STATUS ends at 0x100.
- Overflow:
  - Stimulus: out_ready=0, push 10 words (DEPTH=8).
  - Required: STATUS = 32'h0002_0208; drained data equals words 1..8. Then write STATUS and read 0x0000_0208 with ovf cleared.
- Full push+pop:
  - Stimulus: FIFO full, out_ready=1 and push 0xAA in the same cycle.
  - Required: count stays 8, ovf_cnt unchanged, 0xAA emerges last.
- Enable/flush:
  - Stimulus: CTRL=0 with 4 words queued.
  - Required: out_valid stays 0 for 20 cycles. Then CTRL=3 -> count 0, out_valid 0, en 1.
- Decode/counter:
  - Read addr 0x0000_0040 -> hit=0, rdata=0.
  - Read BASE+0x20 -> hit=1, rdata=0.
  - Write CYCLE, then read it 5 cycles later -> 5.

Source files
------------

// File: rtl/dbus_mmio_pkg.sv
// Shared constants for the data-bus MMIO responder: register word offsets
// and bit positions inside the STATUS and CTRL registers.
package dbus_mmio_pkg;

  localparam logic [5:0] OFF_TXDATA = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_CYCLE  = 6'h02;
  localparam logic [5:0] OFF_CTRL   = 6'h03;

  localparam int ST_COUNT_LSB = 0;
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVF_LSB   = 16;

  localparam int EN_BIT    = 0;
  localparam int FLUSH_BIT = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Synchronous FIFO with push/pop/flush; the head word is presented
// combinationally from the read pointer.
module mmio_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  // A full FIFO still accepts a push when a word leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dbus_mmio_responder.sv
// MMIO target on the single-cycle core's data bus: TX FIFO port, status,
// free-running cycle counter and control register in a 256-byte window.
module dbus_mmio_responder
  import dbus_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [5:0]  offset;
  logic        wr_en;
  logic        push;
  logic        pop;
  logic        flush;
  logic        overflow;
  logic        en;
  logic [7:0]  ovf_cnt;
  logic [31:0] cyc;
  logic [AW:0] count;
  logic [7:0]  count8;
  logic        full;
  logic        empty;
  logic        unused_addr;

  assign offset      = addr[7:2];
  assign unused_addr = ^addr[1:0];
  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr_en       = mem_write & hit;
  assign push        = wr_en & (offset == OFF_TXDATA);
  assign flush       = wr_en & (offset == OFF_CTRL) & wdata[FLUSH_BIT];
  assign out_valid   = en & ~empty;
  assign pop         = out_valid & out_ready;
  assign overflow    = push & full & ~pop;
  assign count8      = 8'(count);

  mmio_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (wdata),
    .count (count),
    .full  (full),
    .empty (empty),
    .head  (out_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b1;
      ovf_cnt <= 8'd0;
      cyc     <= 32'd0;
    end else begin
      cyc <= (wr_en && offset == OFF_CYCLE) ? 32'd0 : cyc + 32'd1;
      if (wr_en && offset == OFF_CTRL) en <= wdata[EN_BIT];
      if (wr_en && offset == OFF_STATUS) begin
        ovf_cnt <= 8'd0;
      end else if (overflow) begin
        ovf_cnt <= sat_inc8(ovf_cnt);
      end
    end
  end

  // Reads are combinational so the core sees data in the same cycle.
  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        OFF_STATUS: begin
          rdata[ST_COUNT_LSB +: 8] = count8;
          rdata[ST_EMPTY_BIT]      = empty;
          rdata[ST_FULL_BIT]       = full;
          rdata[ST_OVF_LSB +: 8]   = ovf_cnt;
        end
        OFF_CYCLE: rdata = cyc;
        OFF_CTRL:  rdata[EN_BIT] = en;
        default:   rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_dbus_mmio_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences
// and a randomized phase checked against a queue-based reference model.
module tb_dbus_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  always #5 clk = ~clk;

  dbus_mmio_responder dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .hit       (hit),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_en;
  int          m_ovf;
  logic [31:0] m_cyc;

  typedef struct {
    bit          mw;
    logic [31:0] a;
    logic [31:0] d;
    bit          rdy;
    bit          exp_hit;
    bit          chk_rd;
    logic [31:0] exp_rdata;
    bit          exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[17];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(logic [31:0] a);
    int n;
    n = mq.size();
    if (a[31:8] != BASE[31:8]) return 32'd0;
    case (a[7:2])
      6'd1:    return 32'(n + (n == 0 ? 256 : 0) + (n == 8 ? 512 : 0) + m_ovf * 65536);
      6'd2:    return m_cyc;
      6'd3:    return m_en ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en  = 1'b1;
    m_ovf = 0;
    m_cyc = 32'd0;
  endtask

  // Apply the current bus inputs to the model as one clock edge.
  task automatic model_edge();
    bit wr;
    bit popm;
    logic [5:0] off;
    wr   = mem_write && (addr[31:8] == BASE[31:8]);
    off  = addr[7:2];
    popm = m_en && (mq.size() > 0) && out_ready;
    m_cyc = (wr && off == 6'd2) ? 32'd0 : m_cyc + 32'd1;
    if (wr && off == 6'd3 && wdata[1]) mq.delete();
    else if (popm) void'(mq.pop_front());
    if (wr && off == 6'd0) begin
      if (mq.size() < 8) mq.push_back(wdata);
      else if (m_ovf < 255) m_ovf++;
    end
    if (wr && off == 6'd1) m_ovf = 0;
    if (wr && off == 6'd3) m_en = wdata[0];
  endtask

  task automatic drive(bit mw, logic [31:0] a, logic [31:0] d, bit rdy);
    mem_write = mw;
    addr      = a;
    wdata     = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    bit ev;
    ev = m_en && (mq.size() > 0);
    check({tag, "_hit"}, {31'd0, hit}, {31'd0, addr[31:8] == BASE[31:8]});
    check({tag, "_rdata"}, rdata, model_rdata(addr));
    check({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) check({tag, "_data"}, out_data, mq[0]);
  endtask

  initial begin
    logic [31:0] exp_drain[8];
    logic [5:0]  off;
    int          r;
    bit          mw;

    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // mw, addr, wdata, rdy, hit, chk_rd, rdata, valid, data
    tbl[0]  = '{1'b0, BASE + 32'h04, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, BASE + 32'h0C, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, BASE + 32'h00, 32'h11,   1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    tbl[3]  = '{1'b1, BASE + 32'h00, 32'h22,   1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 32'h11};
    tbl[4]  = '{1'b1, BASE + 32'h00, 32'h33,   1'b1, 1'b1, 1'b1, 32'h0,         1'b1, 32'h22};
    tbl[5]  = '{1'b0, BASE + 32'h04, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 32'h33};
    tbl[6]  = '{1'b0, BASE + 32'h04, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_0040, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0};
    tbl[8]  = '{1'b1, BASE + 32'h08, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[9]  = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd0,         1'b0, 32'h0};
    tbl[10] = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd1,         1'b0, 32'h0};
    tbl[11] = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd2,         1'b0, 32'h0};
    tbl[12] = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd3,         1'b0, 32'h0};
    tbl[13] = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd4,         1'b0, 32'h0};
    tbl[14] = '{1'b0, BASE + 32'h08, 32'h0,    1'b0, 1'b1, 1'b1, 32'd5,         1'b0, 32'h0};
    tbl[15] = '{1'b0, BASE + 32'h20, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0};
    tbl[16] = '{1'b0, BASE + 32'h0F, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rdy);
      check($sformatf("tbl%0d_hit", i), {31'd0, hit}, {31'd0, tbl[i].exp_hit});
      if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp_data);
      step();
    end

    // Overflow: ten pushes into an 8-deep FIFO with the sink stalled
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, BASE, 32'h100 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b0);
    check("ovf_status", rdata, 32'h0002_0208);
    check("ovf_head", out_data, 32'h101);
    step();
    drive(1'b1, BASE + 32'h04, 32'hFFFF_FFFF, 1'b0);
    step();
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b0);
    check("ovf_clear", rdata, 32'h0000_0208);
    step();

    // Push and pop together while full
    drive(1'b1, BASE, 32'hAA, 1'b1);
    check("fullpp_head", out_data, 32'h101);
    step();
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b0);
    check("fullpp_status", rdata, 32'h0000_0208);
    step();
    for (int i = 0; i < 7; i++) exp_drain[i] = 32'h102 + 32'(i);
    exp_drain[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, BASE + 32'h04, 32'h0, 1'b1);
      check($sformatf("drain%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("drain%0d_data", i), out_data, exp_drain[i]);
      step();
    end
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b1);
    check("drain_status", rdata, 32'h0000_0100);
    step();

    // Disabled stream holds its words; flush empties and re-enables
    drive(1'b1, BASE + 32'h0C, 32'h0, 1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, BASE, 32'hC0 + 32'(i), 1'b1);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, BASE + 32'h04, 32'h0, 1'b1);
      check($sformatf("dis%0d_valid", i), {31'd0, out_valid}, 32'd0);
      step();
    end
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b1);
    check("dis_status", rdata, 32'h0000_0004);
    step();
    drive(1'b1, BASE + 32'h0C, 32'h3, 1'b1);
    step();
    drive(1'b0, BASE + 32'h0C, 32'h0, 1'b1);
    check("flush_ctrl", rdata, 32'h1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    step();
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b1);
    check("flush_status", rdata, 32'h0000_0100);
    step();

    // Asynchronous reset in the middle of a stalled stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BASE, 32'hE0 + 32'(i), 1'b0);
      step();
    end
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b0);
    check("prerst_valid", {31'd0, out_valid}, 32'd1);
    check("prerst_status", rdata, 32'h0000_0003);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, BASE + 32'h04, 32'h0, 1'b0);
    check("rst_status", rdata, 32'h0000_0100);
    drive(1'b0, BASE + 32'h0C, 32'h0, 1'b0);
    check("rst_ctrl", rdata, 32'h1);
    drive(1'b0, BASE + 32'h08, 32'h0, 1'b0);
    check("rst_cycle0", rdata, 32'd0);
    step();
    drive(1'b0, BASE + 32'h08, 32'h0, 1'b0);
    check("rst_cycle1", rdata, 32'd1);
    step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      r  = int'($urandom_range(0, 99));
      mw = ($urandom_range(0, 2) != 0);
      if (r < 50)      off = 6'd0;
      else if (r < 60) off = 6'd1;
      else if (r < 66) off = 6'd2;
      else if (r < 76) off = 6'd3;
      else             off = 6'($urandom_range(4, 63));
      if (r >= 92) begin
        addr = $urandom();
        if (addr[31:8] == BASE[31:8]) addr[31] = 1'b0;
      end else begin
        addr = {BASE[31:8], off, 2'($urandom_range(0, 3))};
      end
      wdata = $urandom();
      if (off == 6'd3) begin
        wdata[0] = ($urandom_range(0, 4) != 0);
        wdata[1] = ($urandom_range(0, 9) == 0);
      end
      drive(mw, addr, wdata, (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      check_model($sformatf("rnd%0d", c));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
